// File: rtl/dac_spi_pkg.sv
// Shared types and helpers for the DAC SPI transmit engine.
package dac_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    LAG,
    GAP
  } state_e;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int clog2_min1(input int v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/dac_spi_sclk_gen.sv
// Half-period tick generator: while enabled, pulses tick_o once every DIV cycles.
module dac_spi_sclk_gen
  import dac_spi_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam int HPW = clog2_min1(DIV);
  localparam logic [HPW-1:0] HP_LAST = HPW'(DIV - 1);

  logic [HPW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == HP_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || tick_o) cnt_d = '0;
    else                 cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dac_spi_master.sv
// SPI transmit engine for the DAC family: one word per TR/READY handshake,
// shifted to one of NUM_CH chip-selected DACs with selectable CPOL/CPHA.
module dac_spi_master
  import dac_spi_pkg::*;
#(
  parameter int WIDTH     = 24,
  parameter int DIV       = 1,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b1,
  parameter int NUM_CH    = 1,
  parameter int CS_IDLE   = 2,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                            CLK,
  input  logic                            RESET_N,
  input  logic                            TR,
  input  logic [WIDTH-1:0]                DATA,
  input  logic [clog2_min1(NUM_CH)-1:0]   CH,
  output logic                            READY,
  output logic [NUM_CH-1:0]               DA_CS,
  output logic                            DA_SCLK,
  output logic                            DA_SDO,
  output logic                            DONE
);

  localparam int CHW = clog2_min1(NUM_CH);
  localparam int BCW = $clog2(2 * WIDTH);
  localparam int GW  = clog2_min1(CS_IDLE);
  localparam logic [BCW-1:0] BC_LAST  = BCW'(2 * WIDTH - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(CS_IDLE - 1);
  localparam logic [CHW:0]   NUM_CH_V = (CHW + 1)'(NUM_CH);

  state_e            state_q;
  logic [WIDTH-1:0]  sr_q;
  logic [BCW-1:0]    bc_q;
  logic [GW-1:0]     gap_q;
  logic [NUM_CH-1:0] cs_q;
  logic              sclk_q, sdo_q, ready_q, done_q;
  logic              tick, en, accept, advance;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  assign en     = (state_q == LEAD) || (state_q == SHIFT) || (state_q == LAG);
  assign accept = (state_q == IDLE) && TR && ({1'b0, CH} < NUM_CH_V);
  // CPHA=1 presents a new bit on every leading edge; CPHA=0 on every trailing
  // edge except the final one, since the first bit is already out in LEAD.
  assign advance = (state_q == SHIFT) && tick &&
                   (CPHA ? !bc_q[0] : (bc_q[0] && (bc_q != BC_LAST)));

  dac_spi_sclk_gen #(.DIV(DIV)) u_sclk_gen (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .en_i   (en),
    .tick_o (tick)
  );

  always_ff @(posedge CLK) begin
    if (accept)       sr_q <= CPHA ? DATA : shift_out(DATA);
    else if (advance) sr_q <= shift_out(sr_q);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cs_q    <= '1;
      sclk_q  <= CPOL;
      sdo_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      bc_q    <= '0;
      gap_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= LEAD;
            ready_q <= 1'b0;
            cs_q    <= ~(NUM_CH'(1) << CH);
            sdo_q   <= CPHA ? 1'b0 : first_bit(DATA);
          end
        end
        LEAD: begin
          if (tick) state_q <= SHIFT;
        end
        SHIFT: begin
          if (tick) begin
            sclk_q <= ~sclk_q;
            if (advance) sdo_q <= first_bit(sr_q);
            if (bc_q == BC_LAST) begin
              state_q <= LAG;
              bc_q    <= '0;
            end else begin
              bc_q <= bc_q + 1'b1;
            end
          end
        end
        LAG: begin
          if (tick) begin
            state_q <= GAP;
            cs_q    <= '1;
            sdo_q   <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_q   <= '0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign READY   = ready_q;
  assign DA_CS   = cs_q;
  assign DA_SCLK = sclk_q;
  assign DA_SDO  = sdo_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_dac_spi_master.sv
// Scoreboard bench for dac_spi_master: two instances (MSB-first mode 1 with
// three channels, LSB-first mode 2 with DIV=4) decoded by a pin-level monitor.
module tb_dac_spi_master;
  import dac_spi_pkg::*;

  localparam int W0 = 24, DIV0 = 1, CSI0 = 2;
  localparam int W1 = 16, DIV1 = 4, CSI1 = 3;

  typedef struct packed {
    logic [1:0]  ch;
    logic [23:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        tr0 = 1'b0, tr1 = 1'b0;
  logic [23:0] data0 = '0;
  logic [15:0] data1 = '0;
  logic [1:0]  ch0 = '0;
  logic [0:0]  ch1 = '0;
  logic        ready0, ready1, sclk0, sclk1, sdo0, sdo1, done0, done1;
  logic [2:0]  cs0;
  logic [0:0]  cs1;

  dac_spi_master #(
    .WIDTH(W0), .DIV(DIV0), .CPOL(SPI_MODE1[1]), .CPHA(SPI_MODE1[0]),
    .NUM_CH(3), .CS_IDLE(CSI0), .LSB_FIRST(1'b0)
  ) u_dut0 (
    .CLK(clk), .RESET_N(rst_n), .TR(tr0), .DATA(data0), .CH(ch0),
    .READY(ready0), .DA_CS(cs0), .DA_SCLK(sclk0), .DA_SDO(sdo0), .DONE(done0)
  );

  dac_spi_master #(
    .WIDTH(W1), .DIV(DIV1), .CPOL(SPI_MODE2[1]), .CPHA(SPI_MODE2[0]),
    .NUM_CH(1), .CS_IDLE(CSI1), .LSB_FIRST(1'b1)
  ) u_dut1 (
    .CLK(clk), .RESET_N(rst_n), .TR(tr1), .DATA(data1), .CH(ch1),
    .READY(ready1), .DA_CS(cs1), .DA_SCLK(sclk1), .DA_SDO(sdo1), .DONE(done1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   acc_t0[$];
  int   cyc = 0;

  logic        prev_low[2], prev_sclk[2], gap_act[2], sdo_fall[2];
  logic [31:0] bits[2];
  int          nbits[2], pulses[2], lowcnt[2], chan[2], gapcnt[2];
  int          run[2], nedges[2], hp_err[2], frames[2], dones[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake observer: every accepted request becomes an expected frame.
  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (tr0 && ready0 && ch0 < 2'd3) begin
        q0.push_back({ch0, data0});
        acc_t0.push_back(cyc);
      end
      if (tr1 && ready1) q1.push_back({2'b00, 8'h00, data1});
    end
  end

  task automatic mon(input int d, input logic [2:0] cs, input logic sclk,
                     input logic sdo, input logic done, input logic ready);
    int   w, dv, csi;
    logic cpol, cpha, lsb, low, lead;
    exp_t e;
    w    = (d == 0) ? W0 : W1;
    dv   = (d == 0) ? DIV0 : DIV1;
    csi  = (d == 0) ? CSI0 : CSI1;
    cpol = (d == 0) ? SPI_MODE1[1] : SPI_MODE2[1];
    cpha = (d == 0) ? SPI_MODE1[0] : SPI_MODE2[0];
    lsb  = (d == 0) ? 1'b0 : 1'b1;
    low  = (cs != 3'b111);
    if (done) dones[d]++;
    if (low && !prev_low[d]) begin
      chk("cs_onehot", $countones(~cs), 1);
      chk("sclk_idle_at_cs_fall", sclk, cpol);
      lowcnt[d] = 1; nbits[d] = 0; pulses[d] = 0; nedges[d] = 0;
      run[d] = 0; hp_err[d] = 0; bits[d] = '0; sdo_fall[d] = sdo;
      chan[d] = (!cs[0]) ? 0 : (!cs[1]) ? 1 : 2;
    end else if (low) begin
      lowcnt[d]++;
      if (sclk != prev_sclk[d]) begin
        lead = (prev_sclk[d] == cpol);
        if (nedges[d] > 0 && run[d] != dv) hp_err[d]++;
        nedges[d]++;
        run[d] = 1;
        if (lead) pulses[d]++;
        if (lead != cpha) begin
          if (lsb) bits[d][nbits[d]] = sdo;
          else     bits[d] = {bits[d][30:0], sdo};
          nbits[d]++;
        end
      end else begin
        run[d]++;
      end
    end else if (prev_low[d]) begin
      frames[d]++;
      chk("sb_nonempty", ((d == 0) ? q0.size() : q1.size()) > 0, 1);
      if (((d == 0) ? q0.size() : q1.size()) > 0) begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk("frame_data", bits[d], {8'h00, e.data});
        chk("frame_chan", chan[d], e.ch);
        if (!cpha) chk("sdo_at_cs_fall", sdo_fall[d], lsb ? e.data[0] : e.data[w-1]);
      end
      chk("cs_low_cycles", lowcnt[d], (2 * w + 2) * dv);
      chk("sclk_pulses", pulses[d], w);
      chk("half_period_len", hp_err[d], 0);
      chk("done_at_cs_rise", done, 1'b1);
      chk("sclk_idle_at_cs_rise", sclk, cpol);
      chk("sdo_zero_in_gap", sdo, 1'b0);
      gap_act[d] = 1'b1;
      gapcnt[d] = 0;
    end
    if (!low && gap_act[d]) begin
      if (ready) begin
        chk("cs_idle_gap", gapcnt[d], csi);
        gap_act[d] = 1'b0;
      end else begin
        gapcnt[d]++;
      end
    end
    prev_low[d]  = low;
    prev_sclk[d] = sclk;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        prev_low[d] = 1'b0;
        gap_act[d]  = 1'b0;
      end
    end else begin
      mon(0, cs0, sclk0, sdo0, done0, ready0);
      mon(1, {2'b11, cs1}, sclk1, sdo1, done1, ready1);
    end
  end

  task automatic send0(input logic [23:0] d, input logic [1:0] c);
    @(negedge clk);
    tr0 = 1'b1; data0 = d; ch0 = c;
    @(negedge clk);
    tr0 = 1'b0;
  endtask

  task automatic send1(input logic [15:0] d);
    @(negedge clk);
    tr1 = 1'b1; data1 = d; ch1 = 1'b0;
    @(negedge clk);
    tr1 = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ((d == 0) ? (ready0 && q0.size() == 0) : (ready1 && q1.size() == 0)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", ok, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    int n_acc, f0;
    logic ok;
    for (int d = 0; d < 2; d++) begin
      prev_low[d] = 1'b0; prev_sclk[d] = 1'b0; gap_act[d] = 1'b0; sdo_fall[d] = 1'b0;
      bits[d] = '0; nbits[d] = 0; pulses[d] = 0; lowcnt[d] = 0; chan[d] = 0;
      gapcnt[d] = 0; run[d] = 0; nedges[d] = 0; hp_err[d] = 0; frames[d] = 0; dones[d] = 0;
    end

    #22;
    chk("rst_cs0", cs0, 3'b111);
    chk("rst_sclk0", sclk0, 1'b0);
    chk("rst_sdo0", sdo0, 1'b0);
    chk("rst_ready0", ready0, 1'b1);
    chk("rst_done0", done0, 1'b0);
    chk("rst_cs1", cs1, 1'b1);
    chk("rst_sclk1", sclk1, 1'b1);
    chk("rst_ready1", ready1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    send0(24'h00ABCD, 2'd0);
    wait_idle(0);
    send0(24'h5A3C96, 2'd2);
    wait_idle(0);

    // Out-of-range channel must be dropped silently.
    @(negedge clk);
    tr0 = 1'b1; ch0 = 2'd3; data0 = 24'hFFFFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drop_ready", ready0, 1'b1);
      chk("drop_cs", cs0, 3'b111);
      chk("drop_done", done0, 1'b0);
    end
    tr0 = 1'b0;

    // TR held high across three frames while DATA keeps changing.
    n_acc = acc_t0.size();
    f0 = frames[0];
    @(negedge clk);
    tr0 = 1'b1; ch0 = 2'd1; data0 = 24'h111111;
    for (int i = 0; i < 1000 && acc_t0.size() < n_acc + 3; i++) begin
      @(negedge clk);
      data0 = 24'($urandom);
    end
    tr0 = 1'b0;
    chk("b2b_accepts", acc_t0.size() - n_acc, 3);
    wait_idle(0);
    chk("b2b_frames", frames[0] - f0, 3);
    if (acc_t0.size() >= n_acc + 3) begin
      chk("b2b_period_1", acc_t0[n_acc+1] - acc_t0[n_acc], (2 * W0 + 2) * DIV0 + CSI0 + 1);
      chk("b2b_period_2", acc_t0[n_acc+2] - acc_t0[n_acc+1], (2 * W0 + 2) * DIV0 + CSI0 + 1);
    end

    send1(16'h8001);
    wait_idle(1);
    send1(16'h0001);
    wait_idle(1);
    send1(16'hC3A5);
    wait_idle(1);

    // Reset in the middle of a frame.
    send0(24'hFFFFFF, 2'd1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (nbits[0] >= 10) begin
        ok = 1'b1;
        break;
      end
    end
    chk("midframe_reach_bit10", ok, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs", cs0, 3'b111);
    chk("abort_sclk", sclk0, 1'b0);
    chk("abort_sdo", sdo0, 1'b0);
    chk("abort_ready", ready0, 1'b1);
    chk("abort_done", done0, 1'b0);
    if (q0.size() > 0) void'(q0.pop_front());
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    send0(24'h123456, 2'd1);
    wait_idle(0);

    chk("frames0_total", frames[0], 6);
    chk("dones0_total", dones[0], 6);
    chk("frames1_total", frames[1], 3);
    chk("dones1_total", dones[1], 3);
    chk("sb0_empty", q0.size(), 0);
    chk("sb1_empty", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
